// File: rtl/router_fsm.sv
// -----------------------------------------------------------------------------
// router_fsm
//   Packet-level controller for the 1x3 router. It decodes the destination
//   address carried in the header byte, waits for the target FIFO to drain,
//   then sequences the header, payload and parity loads into router_reg and
//   router_sync. It stalls while the selected FIFO is full and abandons the
//   packet when the selected destination signals a soft reset.
//
// Ports
//   clock          system clock, rising edge
//   reset          asynchronous, active-high
//   pkt_valid      source is presenting packet bytes
//   data_in[1:0]   address field of the header byte
//   parity_done    router_reg has captured the parity byte
//   low_pkt_valid  router_reg saw pkt_valid fall while the FIFO was full
//   fifo_full      selected FIFO full (from router_sync)
//   fifo_empty_0/1/2  per-FIFO empty flags
//   soft_reset_0/1/2  per-FIFO read-timeout flags (from router_sync)
//   detect_add     high in DECODE_ADDRESS
//   lfd_state      high in LOAD_FIRST_DATA
//   ld_state       high in LOAD_DATA
//   laf_state      high in LOAD_AFTER_FULL
//   full_state     high in FIFO_FULL_STATE
//   write_enb_reg  FIFO write strobe to router_sync
//   rst_int_reg    high in CHECK_PARITY_ERROR
//   busy           source must hold its current byte
// -----------------------------------------------------------------------------
module router_fsm #(
  parameter logic [1:0] INVALID_ADDR = 2'b11
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg,
  output logic       busy
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_AFTER_FULL    = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } state_t;

  state_t     state;
  logic [1:0] addr;

  logic       hdr_valid;     // header presents an acceptable destination
  logic       hdr_empty;     // empty flag of the FIFO named by data_in
  logic       sel_empty;     // empty flag of the latched destination
  logic       sel_soft_rst;  // soft reset of the latched destination

  // The header is only taken when the source is driving and the address is
  // not the reserved value; otherwise the FSM idles in DECODE_ADDRESS.
  assign hdr_valid = pkt_valid && (data_in != INVALID_ADDR);

  always_comb begin
    hdr_empty = 1'b0;
    case (data_in)
      2'd0:    hdr_empty = fifo_empty_0;
      2'd1:    hdr_empty = fifo_empty_1;
      2'd2:    hdr_empty = fifo_empty_2;
      default: hdr_empty = 1'b0;
    endcase
  end

  always_comb begin
    sel_empty    = 1'b0;
    sel_soft_rst = 1'b0;
    case (addr)
      2'd0: begin
        sel_empty    = fifo_empty_0;
        sel_soft_rst = soft_reset_0;
      end
      2'd1: begin
        sel_empty    = fifo_empty_1;
        sel_soft_rst = soft_reset_1;
      end
      2'd2: begin
        sel_empty    = fifo_empty_2;
        sel_soft_rst = soft_reset_2;
      end
      default: begin
        sel_empty    = 1'b0;
        sel_soft_rst = 1'b0;
      end
    endcase
  end

  // State register and transition logic. A soft reset from the selected
  // destination overrides every other transition once a packet is underway.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= DECODE_ADDRESS;
      addr  <= 2'd0;
    end else if ((state != DECODE_ADDRESS) && sel_soft_rst) begin
      state <= DECODE_ADDRESS;
    end else begin
      case (state)
        DECODE_ADDRESS: begin
          if (hdr_valid) begin
            addr  <= data_in;
            state <= hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
          end
        end
        LOAD_FIRST_DATA: state <= LOAD_DATA;
        LOAD_DATA: begin
          // A full FIFO must be honoured before the packet can be closed.
          if (fifo_full)
            state <= FIFO_FULL_STATE;
          else if (!pkt_valid)
            state <= LOAD_PARITY;
        end
        FIFO_FULL_STATE: begin
          if (!fifo_full)
            state <= LOAD_AFTER_FULL;
        end
        LOAD_AFTER_FULL: begin
          if (parity_done)
            state <= DECODE_ADDRESS;
          else if (low_pkt_valid)
            state <= LOAD_PARITY;
          else
            state <= LOAD_DATA;
        end
        LOAD_PARITY: state <= CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: begin
          state <= fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        end
        WAIT_TILL_EMPTY: begin
          if (sel_empty)
            state <= LOAD_FIRST_DATA;
        end
        default: state <= DECODE_ADDRESS;
      endcase
    end
  end

  // Moore output decode: depends on state only, so an asynchronous reset
  // is visible on the outputs immediately.
  always_comb begin
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    full_state    = 1'b0;
    write_enb_reg = 1'b0;
    rst_int_reg   = 1'b0;
    busy          = 1'b0;
    case (state)
      DECODE_ADDRESS: detect_add = 1'b1;
      LOAD_FIRST_DATA: begin
        lfd_state = 1'b1;
        busy      = 1'b1;
      end
      LOAD_DATA: begin
        ld_state      = 1'b1;
        write_enb_reg = 1'b1;
      end
      LOAD_AFTER_FULL: begin
        laf_state     = 1'b1;
        write_enb_reg = 1'b1;
        busy          = 1'b1;
      end
      FIFO_FULL_STATE: begin
        full_state = 1'b1;
        busy       = 1'b1;
      end
      LOAD_PARITY: begin
        write_enb_reg = 1'b1;
        busy          = 1'b1;
      end
      CHECK_PARITY_ERROR: begin
        rst_int_reg = 1'b1;
        busy        = 1'b1;
      end
      WAIT_TILL_EMPTY: busy = 1'b1;
      default: detect_add = 1'b1;
    endcase
  end

endmodule
